// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I instruction fetch stage.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   typedef struct packed {
      logic [XLEN-1:0] inst;
      logic [XLEN-1:0] pc;
      logic            misalign;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with flush; head and count are registered state, 0-cycle read of head.
// Push is accepted when not full or when a pop happens in the same cycle; flush overrides push/pop.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4,
   localparam int AW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   input  logic             flush,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             push_en;
   logic             pop_en;

   assign pop_en  = pop & (cnt != '0);
   assign push_en = push & ((cnt != CW'(DEPTH)) | pop_en);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push_en) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop_en) rd_ptr <= rd_ptr + AW'(1);
         if (push_en && !pop_en)      cnt <= cnt + CW'(1);
         else if (!push_en && pop_en) cnt <= cnt - CW'(1);
      end
   end

   assign head  = mem[rd_ptr];
   assign count = cnt;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, in-order imem requests, FIFO to decode (rsp in t -> out_valid in t+1); requests stall when buffered+in-flight reaches DEPTH.
// Optional IF_MISALIGN_CHECK_EN halts on a misaligned redirect and emits one flagged NOP entry.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int              DEPTH    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_inst,
`ifdef IF_MISALIGN_CHECK_EN
   output logic            out_misalign,
`endif
   output logic [XLEN-1:0] out_pc
);

   localparam int            CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam int            EW      = $bits(fetch_entry_t);

   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] target;
   logic [CW-1:0]   outstanding;
   logic [CW-1:0]   outstanding_nxt;
   logic [CW-1:0]   drop_cnt;
   logic [CW-1:0]   count;
   logic [CW-1:0]   unused_tag_count;
   logic [XLEN-1:0] tag_pc;
   logic            fire;
   logic            rsp_keep;
   logic            req_block;
   logic            out_push;
   fetch_entry_t    push_entry;
   fetch_entry_t    head_entry;
   logic [EW-1:0]   head_bits;

`ifdef IF_MISALIGN_CHECK_EN
   logic halted;
   logic mis_done;
   logic mis_push;

   assign target    = redirect_pc;
   assign req_block = halted;
   // The flagged entry waits until every stale response has been dropped.
   assign mis_push  = halted & ~mis_done & (drop_cnt == '0) & ~redirect_valid;
`else
   logic [1:0] unused_redirect_lsb;
   logic       unused_misalign;

   assign unused_redirect_lsb = redirect_pc[1:0];
   assign unused_misalign     = head_entry.misalign;
   assign target              = {redirect_pc[XLEN-1:2], 2'b00};
   assign req_block           = 1'b0;
`endif

   assign imem_req_valid = rst_n & ((count + outstanding) < DEPTH_C) & ~req_block;
   assign imem_req_addr  = pc;
   assign fire           = imem_req_valid & imem_req_ready;
   assign rsp_keep       = imem_rsp_valid & (drop_cnt == '0) & ~redirect_valid;

   always_comb begin
      outstanding_nxt = outstanding;
      if (fire && !imem_rsp_valid)      outstanding_nxt = outstanding + CW'(1);
      else if (!fire && imem_rsp_valid) outstanding_nxt = outstanding - CW'(1);
   end

   always_comb begin
      push_entry = '{inst: imem_rsp_data, pc: tag_pc, misalign: 1'b0};
      out_push   = rsp_keep;
`ifdef IF_MISALIGN_CHECK_EN
      if (mis_push) begin
         push_entry = '{inst: NOP_INST, pc: pc, misalign: 1'b1};
         out_push   = 1'b1;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc          <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
`ifdef IF_MISALIGN_CHECK_EN
         halted      <= 1'b0;
         mis_done    <= 1'b0;
`endif
      end else begin
         outstanding <= outstanding_nxt;
         if (redirect_valid) begin
            pc       <= target;
            // Everything still in flight after this cycle belongs to the old path.
            drop_cnt <= outstanding_nxt;
`ifdef IF_MISALIGN_CHECK_EN
            halted   <= (redirect_pc[1:0] != 2'b00);
            mis_done <= 1'b0;
`endif
         end else begin
            if (fire) pc <= pc + 32'd4;
            if (imem_rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
`ifdef IF_MISALIGN_CHECK_EN
            if (mis_push) mis_done <= 1'b1;
`endif
         end
      end
   end

   fetch_fifo #(.WIDTH(XLEN), .DEPTH(DEPTH)) u_tag_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fire & ~redirect_valid),
      .push_data (pc),
      .pop       (rsp_keep),
      .flush     (redirect_valid),
      .head      (tag_pc),
      .count     (unused_tag_count)
   );

   fetch_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_out_q (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (out_push),
      .push_data (push_entry),
      .pop       (out_ready),
      .flush     (redirect_valid),
      .head      (head_bits),
      .count     (count)
   );

   assign head_entry = fetch_entry_t'(head_bits);
   assign out_valid  = (count != '0);
   assign out_inst   = head_entry.inst;
   assign out_pc     = head_entry.pc;
`ifdef IF_MISALIGN_CHECK_EN
   assign out_misalign = head_entry.misalign;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: in-order memory model with variable latency, stream model of expected PCs.
module tb_instruction_fetch;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
`ifdef IF_MISALIGN_CHECK_EN
   logic        out_misalign;
`endif

   always #5 clk = ~clk;

   instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
`ifdef IF_MISALIGN_CHECK_EN
      .out_misalign   (out_misalign),
`endif
      .out_pc         (out_pc)
   );

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;

   typedef struct {
      logic [31:0] tgt;
      int          lat;
      int          n;
      logic [31:0] exp_first;
      logic [31:0] exp_last;
   } vec_t;

   mreq_t       mq[$];
   logic [31:0] outs_pc[$];
   int          cyc = 0;
   int          lat = 1;
   int          last_due = 0;
   int          nfires = 0;
   int          nouts = 0;
   int          passes = 0;
   int          total = 0;
   logic [31:0] exp_req;
   logic [31:0] exp_out;
   logic [31:0] mis_pc;
   bit          chk_empty;
   bit          halt_mode;
   bit          mis_pending;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // One clock cycle: drive inputs after the falling edge, check model, advance to next falling edge.
   task automatic tick(input bit rdy, input bit ordy, input bit redir, input logic [31:0] tgt);
      int due;
      if (mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(mq[0].addr);
         void'(mq.pop_front());
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
      imem_req_ready = rdy;
      out_ready      = ordy;
      redirect_valid = redir;
      redirect_pc    = tgt;
      #1;
      if (chk_empty) begin
         check("flush_empty", {31'd0, out_valid}, 32'd0);
         chk_empty = 1'b0;
      end
      if (halt_mode) begin
         check("halt_no_req", {31'd0, imem_req_valid}, 32'd0);
         if (!mis_pending) check("halt_no_out", {31'd0, out_valid}, 32'd0);
      end
      if (imem_req_valid && rdy) begin
         check("req_addr", imem_req_addr, exp_req);
         due = cyc + lat;
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mq.push_back('{imem_req_addr, due});
         exp_req = exp_req + 32'd4;
         nfires++;
      end
      if (out_valid && ordy && !redir) begin
         nouts++;
         outs_pc.push_back(out_pc);
         if (mis_pending) begin
            check("mis_pc", out_pc, mis_pc);
            check("mis_inst", out_inst, 32'h0000_0013);
`ifdef IF_MISALIGN_CHECK_EN
            check("mis_flag", {31'd0, out_misalign}, 32'd1);
`endif
            mis_pending = 1'b0;
         end else begin
            check("out_pc", out_pc, exp_out);
            check("out_inst", out_inst, mem_word(exp_out));
`ifdef IF_MISALIGN_CHECK_EN
            check("out_misalign", {31'd0, out_misalign}, 32'd0);
`endif
            exp_out = exp_out + 32'd4;
         end
      end
      if (redir) begin
         chk_empty = 1'b1;
`ifdef IF_MISALIGN_CHECK_EN
         exp_req     = tgt;
         exp_out     = tgt;
         halt_mode   = (tgt[1:0] != 2'b00);
         mis_pending = halt_mode;
         mis_pc      = tgt;
`else
         exp_req = {tgt[31:2], 2'b00};
         exp_out = {tgt[31:2], 2'b00};
`endif
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n          = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'h0;
      out_ready      = 1'b0;
      mq.delete();
      outs_pc.delete();
      halt_mode   = 1'b0;
      mis_pending = 1'b0;
      chk_empty   = 1'b0;
      exp_req     = 32'h0;
      exp_out     = 32'h0;
      @(posedge clk);
      @(negedge clk);
      check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_inst", out_inst, 32'd0);
      check("rst_out_pc", out_pc, 32'd0);
      rst_n = 1'b1;
      #1;
      check("first_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("first_req_addr", imem_req_addr, 32'h0);
      last_due = cyc;
   endtask

   task automatic wait_outs(input int n, input int budget);
      for (int i = 0; i < budget && outs_pc.size() < n; i++) tick(1'b1, 1'b1, 1'b0, 32'h0);
   endtask

   task automatic first_out_is(input string name, input logic [31:0] exp);
      logic [31:0] got;
      got = (outs_pc.size() > 0) ? outs_pc[0] : 32'hFFFF_FFFF;
      check(name, got, exp);
   endtask

   initial begin
      vec_t vt[5];
      int   seen;
      vt[0] = '{32'h0000_0100, 3, 4, 32'h0000_0100, 32'h0000_010C};
      vt[1] = '{32'hFFFF_FFF8, 1, 4, 32'hFFFF_FFF8, 32'h0000_0004};
      vt[2] = '{32'h0000_0000, 2, 3, 32'h0000_0000, 32'h0000_0008};
      vt[3] = '{32'h8000_0000, 1, 2, 32'h8000_0000, 32'h8000_0004};
      vt[4] = '{32'h0000_1FFC, 2, 3, 32'h0000_1FFC, 32'h0000_2004};

      rst_n = 1'b0;
      @(negedge clk);

      // Streaming with single-cycle memory
      do_reset();
      lat = 1;
      repeat (12) tick(1'b1, 1'b1, 1'b0, 32'h0);
      seen = 0;
      repeat (8) begin
         if (out_valid) seen++;
         tick(1'b1, 1'b1, 1'b0, 32'h0);
      end
      check("throughput", 32'(seen), 32'd8);

      // Decode stalled: requests stop at DEPTH, order resumes from reset PC
      do_reset();
      nfires = 0;
      repeat (10) tick(1'b1, 1'b0, 1'b0, 32'h0);
      check("stall_reqs", 32'(nfires), 32'd4);
      check("stall_req_low", {31'd0, imem_req_valid}, 32'd0);
      outs_pc.delete();
      repeat (10) tick(1'b1, 1'b1, 1'b0, 32'h0);
      first_out_is("resume_first", 32'h0);

      // Redirect with stale requests in flight
      do_reset();
      lat = 3;
      repeat (2) tick(1'b1, 1'b1, 1'b0, 32'h0);
      outs_pc.delete();
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0100);
      wait_outs(1, 30);
      first_out_is("redir_first", 32'h0000_0100);

      // Redirect coinciding with a response and a pop while the buffer is nearly full
      do_reset();
      lat = 2;
      repeat (5) tick(1'b1, 1'b0, 1'b0, 32'h0);
      check("pre_redir_rsp", {31'd0, (mq.size() > 0 && mq[0].due <= cyc) ? 1'b1 : 1'b0}, 32'd1);
      outs_pc.delete();
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0040);
      wait_outs(2, 30);
      first_out_is("full_redir_first", 32'h0000_0040);

      // Table of redirect targets, including PC wrap-around
      for (int v = 0; v < 5; v++) begin
         lat = vt[v].lat;
         repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
         outs_pc.delete();
         tick(1'b1, 1'b1, 1'b1, vt[v].tgt);
         wait_outs(vt[v].n, 60);
         check("vec_count", {31'd0, outs_pc.size() >= vt[v].n ? 1'b1 : 1'b0}, 32'd1);
         if (outs_pc.size() >= vt[v].n) begin
            check("vec_first", outs_pc[0], vt[v].exp_first);
            check("vec_last", outs_pc[vt[v].n-1], vt[v].exp_last);
         end
      end

`ifdef IF_MISALIGN_CHECK_EN
      // Misaligned redirect: one flagged NOP, then silence until the next redirect
      do_reset();
      lat = 2;
      repeat (3) tick(1'b1, 1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 1'b1, 32'h0000_0102);
      for (int i = 0; i < 20 && !out_valid; i++) tick(1'b1, 1'b0, 1'b0, 32'h0);
      check("mis_valid", {31'd0, out_valid}, 32'd1);
      check("mis_head_flag", {31'd0, out_misalign}, 32'd1);
      check("mis_head_inst", out_inst, 32'h0000_0013);
      check("mis_head_pc", out_pc, 32'h0000_0102);
      repeat (6) tick(1'b1, 1'b1, 1'b0, 32'h0);
      check("mis_consumed", {31'd0, mis_pending}, 32'd0);
      outs_pc.delete();
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0200);
      wait_outs(1, 30);
      first_out_is("mis_recover", 32'h0000_0200);
`else
      // Low redirect bits are ignored
      outs_pc.delete();
      tick(1'b1, 1'b1, 1'b1, 32'h0000_0203);
      wait_outs(1, 30);
      first_out_is("lsb_forced", 32'h0000_0200);
`endif

      // Randomised traffic checked against the stream model
      nouts = 0;
      for (int i = 0; i < 3000; i++) begin
         logic [31:0] tgt;
         if (i % 200 == 0) lat = $urandom_range(1, 3);
         tgt = $urandom;
         if ($urandom % 8 != 0) tgt[1:0] = 2'b00;
         if ($urandom % 16 == 0) tgt = 32'hFFFF_FFF0;
         tick(($urandom % 4) != 0, ($urandom % 10) < 7, ($urandom % 40) == 0, tgt);
      end
      check("random_progress", {31'd0, nouts > 300 ? 1'b1 : 1'b0}, 32'd1);

      // Reset in the middle of traffic clears everything
      do_reset();
      lat = 1;
      outs_pc.delete();
      wait_outs(3, 20);
      first_out_is("post_reset_first", 32'h0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
